// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter sharing one single-port image ROM between NREQ pixel fetchers; one address accepted per cycle.
// Grant 1 cycle after req is sampled, owner-tagged rdata ROM_LAT+1 cycles after grant; requesters hold req until granted.
module sprite_mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    output logic [NREQ-1:0]        gnt,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    output logic [DATA_W-1:0]      rdata,
    output logic [NREQ-1:0]        rvalid
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]                ptr;
    logic [NREQ-1:0]              eligible;
    logic                         win_vld;
    logic [PW-1:0]                win_idx;
    logic [PW:0]                  scan;
    logic [NREQ-1:0]              gnt_nxt;
    logic [ADDR_W-1:0]            win_addr;
    logic [ROM_LAT-1:0][NREQ-1:0] tag_q;

    // A requester granted this cycle is masked so its still-held req is not issued twice.
    assign eligible = req & ~gnt;
    assign win_addr = addr[int'(win_idx) * ADDR_W +: ADDR_W];

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (PW+1)'(k);
            if (scan >= (PW+1)'(NREQ)) begin
                scan = scan - (PW+1)'(NREQ);
            end
            if (!win_vld && eligible[scan[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        gnt_nxt = '0;
        if (win_vld) begin
            gnt_nxt[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            ptr      <= '0;
        end else begin
            gnt    <= gnt_nxt;
            mem_en <= win_vld;
            if (win_vld) begin
                mem_addr <= win_addr;
                ptr      <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
            end
        end
    end

    // gnt itself is tag depth 0; tag_q[ROM_LAT-1] lines up with mem_data for that grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q  <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            tag_q[0] <= gnt;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            rvalid <= tag_q[ROM_LAT-1];
            if (|tag_q[ROM_LAT-1]) begin
                rdata <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench: three arbiters (ROM_LAT 2, 1, 4) share one stimulus stream and are compared each cycle
// against a grant-history model; directed phases pin the model with literal expectations.
module tb_sprite_mem_arbiter;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;
    localparam int NI     = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ-1:0]        gnt_v      [NI];
    logic                   mem_en_v   [NI];
    logic [ADDR_W-1:0]      mem_addr_v [NI];
    logic [DATA_W-1:0]      mem_data_v [NI];
    logic [DATA_W-1:0]      rdata_v    [NI];
    logic [NREQ-1:0]        rvalid_v   [NI];

    always #5 clk = ~clk;

    sprite_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt_v[0]), .mem_en(mem_en_v[0]),
        .mem_addr(mem_addr_v[0]), .mem_data(mem_data_v[0]), .rdata(rdata_v[0]), .rvalid(rvalid_v[0]));
    sprite_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt_v[1]), .mem_en(mem_en_v[1]),
        .mem_addr(mem_addr_v[1]), .mem_data(mem_data_v[1]), .rdata(rdata_v[1]), .rvalid(rvalid_v[1]));
    sprite_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt_v[2]), .mem_en(mem_en_v[2]),
        .mem_addr(mem_addr_v[2]), .mem_data(mem_data_v[2]), .rdata(rdata_v[2]), .rvalid(rvalid_v[2]));

    function automatic int lat_of(input int n);
        return (n == 0) ? 2 : (n == 1) ? 1 : 4;
    endfunction

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] h;
        h = (a * 19'd37) ^ (a >> 7) ^ 19'h0a5;
        return h[DATA_W-1:0];
    endfunction

    // ROM models: data for the address presented in cycle X is driven during cycle X+lat.
    logic [ADDR_W-1:0] rh [NI][6];
    always @(negedge clk) begin
        for (int n = 0; n < NI; n++) begin
            for (int j = 5; j > 0; j--) rh[n][j] = rh[n][j-1];
            rh[n][0]      = mem_addr_v[n];
            mem_data_v[n] = rom_word(rh[n][lat_of(n)]);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int load    = 50;
    int g2_cnt  = 0;

    // Model state: current-cycle grant plus a history of grants/addresses (index = cycles ago).
    logic [NREQ-1:0]   m_gnt;
    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    int                m_ptr;
    logic [NREQ-1:0]   gq [6];
    logic [ADDR_W-1:0] aq [6];
    logic [NREQ-1:0]   m_rvalid [NI];
    logic [DATA_W-1:0] m_rdata  [NI];

    logic [7:0] pat_g, pr1, pr2, pr4;
    logic [3:0] fc_g  [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8};
    logic [3:0] fc_rv [8] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt  = '0;
        m_en   = 1'b0;
        m_addr = '0;
        m_ptr  = 0;
        for (int j = 0; j < 6; j++) begin
            gq[j] = '0;
            aq[j] = '0;
        end
        for (int n = 0; n < NI; n++) begin
            m_rvalid[n] = '0;
            m_rdata[n]  = '0;
        end
    endtask

    // Advance the model across one rising edge, using the inputs the DUT is about to sample.
    task automatic model_step();
        logic [NREQ-1:0] elig;
        int win;
        int idx;
        if (rst) begin
            model_reset();
            return;
        end
        for (int n = 0; n < NI; n++) begin
            m_rvalid[n] = gq[lat_of(n)];
            if (gq[lat_of(n)] != '0) m_rdata[n] = rom_word(aq[lat_of(n)]);
        end
        elig = req & ~m_gnt;
        win  = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && elig[idx]) win = idx;
        end
        m_gnt = '0;
        if (win >= 0) begin
            m_gnt[win] = 1'b1;
            m_en       = 1'b1;
            m_addr     = addr[win*ADDR_W +: ADDR_W];
            m_ptr      = (win + 1) % NREQ;
        end else begin
            m_en = 1'b0;
        end
        for (int j = 5; j > 0; j--) begin
            gq[j] = gq[j-1];
            aq[j] = aq[j-1];
        end
        gq[0] = m_gnt;
        aq[0] = m_addr;
    endtask

    task automatic compare_all();
        for (int n = 0; n < NI; n++) begin
            chk($sformatf("lat%0d_gnt", lat_of(n)), 32'(gnt_v[n]), 32'(m_gnt));
            chk($sformatf("lat%0d_mem_en", lat_of(n)), 32'(mem_en_v[n]), 32'(m_en));
            chk($sformatf("lat%0d_mem_addr", lat_of(n)), 32'(mem_addr_v[n]), 32'(m_addr));
            chk($sformatf("lat%0d_rvalid", lat_of(n)), 32'(rvalid_v[n]), 32'(m_rvalid[n]));
            chk($sformatf("lat%0d_rdata", lat_of(n)), 32'(rdata_v[n]), 32'(m_rdata[n]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released mid-cycle.
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        #1;
        model_reset();
        compare_all();
        for (int n = 0; n < NI; n++) begin
            chk("async_rst_gnt", 32'(gnt_v[n]), 32'd0);
            chk("async_rst_rvalid", 32'(rvalid_v[n]), 32'd0);
            chk("async_rst_rdata", 32'(rdata_v[n]), 32'd0);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        pat_g = 8'b0101_0101;
        pr2   = 8'b1010_1000;
        pr1   = 8'b0101_0100;
        pr4   = 8'b1010_0000;
        rst   = 1'b1;
        req   = '0;
        addr  = '0;
        model_reset();
        tick();
        tick();
        chk("reset_gnt", 32'(gnt_v[0]), 32'd0);
        chk("reset_mem_en", 32'(mem_en_v[0]), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr_v[0]), 32'd0);
        chk("reset_rvalid", 32'(rvalid_v[0]), 32'd0);
        chk("reset_rdata", 32'(rdata_v[0]), 32'd0);

        // Single requester held high.
        rst = 1'b0;
        req = 4'b0001;
        addr[0 +: ADDR_W] = 19'd18000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("single_gnt_c%0d", c), 32'(gnt_v[0][0]), 32'(pat_g[c-1]));
            chk($sformatf("single_rv_lat2_c%0d", c), 32'(rvalid_v[0][0]), 32'(pr2[c-1]));
            chk($sformatf("single_rv_lat1_c%0d", c), 32'(rvalid_v[1][0]), 32'(pr1[c-1]));
            chk($sformatf("single_rv_lat4_c%0d", c), 32'(rvalid_v[2][0]), 32'(pr4[c-1]));
            if (c == 1) chk("single_mem_addr", 32'(mem_addr_v[0]), 32'd18000);
        end
        chk("single_rdata", 32'(rdata_v[0]), 32'(rom_word(19'd18000)));

        // Reset with reads still in flight; none of them may surface.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int n = 0; n < NI; n++) chk("no_stale_rvalid", 32'(rvalid_v[n]), 32'd0);
        end

        // Full contention from ptr=0.
        req = 4'b1111;
        addr[0*ADDR_W +: ADDR_W] = 19'd0;
        addr[1*ADDR_W +: ADDR_W] = 19'd18000;
        addr[2*ADDR_W +: ADDR_W] = 19'd26000;
        addr[3*ADDR_W +: ADDR_W] = 19'd100;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("full_gnt_c%0d", c), 32'(gnt_v[0]), 32'(fc_g[c-1]));
            chk($sformatf("full_rv_c%0d", c), 32'(rvalid_v[0]), 32'(fc_rv[c-1]));
            if (c == 3) chk("full_mem_addr", 32'(mem_addr_v[0]), 32'd26000);
            if (c == 5) chk("full_rdata_1", 32'(rdata_v[0]), 32'(rom_word(19'd18000)));
            if (c == 6) chk("full_rdata_2", 32'(rdata_v[0]), 32'(rom_word(19'd26000)));
            if (c == 7) chk("full_rdata_3", 32'(rdata_v[0]), 32'(rom_word(19'd100)));
            if (c == 8) req = '0;
        end
        tick();
        tick();

        // Pointer fairness: move ptr to 2, then present req[3] and req[1] together.
        req = 4'b0010;
        addr[1*ADDR_W +: ADDR_W] = 19'd500;
        tick();
        chk("ptr_setup_gnt", 32'(gnt_v[0]), 32'h2);
        req = '0;
        tick();
        req = 4'b1010;
        addr[1*ADDR_W +: ADDR_W] = 19'd555;
        addr[3*ADDR_W +: ADDR_W] = 19'd777;
        tick();
        chk("ptr_first_gnt", 32'(gnt_v[0]), 32'h8);
        chk("ptr_first_addr", 32'(mem_addr_v[0]), 32'd777);
        req = 4'b0010;
        tick();
        chk("ptr_second_gnt", 32'(gnt_v[0]), 32'h2);
        chk("ptr_second_addr", 32'(mem_addr_v[0]), 32'd555);
        req = '0;
        tick();
        req = 4'b1111;
        tick();
        chk("ptr_end_gnt", 32'(gnt_v[0]), 32'h4);
        req = 4'b1011;
        repeat (4) begin
            tick();
            req = req & ~m_gnt;
        end
        tick();

        // Drop and re-request by requester 2.
        req = 4'b0100;
        addr[2*ADDR_W +: ADDR_W] = 19'd1234;
        tick();
        g2_cnt += int'(gnt_v[0][2]);
        chk("drop_first_gnt", 32'(gnt_v[0]), 32'h4);
        chk("drop_first_addr", 32'(mem_addr_v[0]), 32'd1234);
        req = '0;
        repeat (5) begin
            tick();
            g2_cnt += int'(gnt_v[0][2]);
        end
        req = 4'b0100;
        addr[2*ADDR_W +: ADDR_W] = 19'd4321;
        tick();
        g2_cnt += int'(gnt_v[0][2]);
        chk("rereq_gnt", 32'(gnt_v[0]), 32'h4);
        chk("rereq_addr", 32'(mem_addr_v[0]), 32'd4321);
        req = '0;
        repeat (4) begin
            tick();
            g2_cnt += int'(gnt_v[0][2]);
        end
        chk("drop_rereq_grant_count", 32'(g2_cnt), 32'd2);

        // Randomized contract-abiding requesters with varying load and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) load = int'($urandom_range(10, 95));
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt[i]) begin
                    if (int'($urandom_range(0, 99)) < load)
                        addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                    else
                        req[i] = 1'b0;
                end else if (!req[i]) begin
                    if (int'($urandom_range(0, 99)) < load) begin
                        req[i] = 1'b1;
                        addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                    end
                end
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
